// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and payload types for the instruction fetch front end.
package if_fetch_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] INVALID_PC       = 64'h0000_0000_0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic              RST_ENABLE       = 1'b1;

    // One buffered instruction handed to ID.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // A redirect is honoured only for a real, word-aligned target.
    function automatic logic redirect_target_ok(input logic [ADDR_W-1:0] target);
        return (target != INVALID_PC) && (target[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO with flush; used for both the instruction buffer and the PC-tag queue.
module if_inst_fifo
    import if_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // Storage array; not reset, occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Fetch PC, credit-based icache request issue, response buffering and EX redirect handling.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] pc_new_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [INST_W-1:0] rsp_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    output logic              bad_redirect_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc, pc_next;
    logic [CNT_W-1:0]  outstanding, outstanding_next;
    logic [CNT_W-1:0]  drop_cnt, drop_cnt_next;
    logic              bad_redirect_next;

    logic              redirect_ok;
    logic              credit_ok;
    logic              issue;
    logic              rsp_ok;
    logic              inst_push;
    logic              inst_pop;
    logic              inst_full, inst_empty;
    logic [CNT_W-1:0]  inst_count;
    logic              tag_full, tag_empty;
    logic [CNT_W-1:0]  tag_count;
    logic [ADDR_W-1:0] tag_pc;
    fetch_entry_t      push_entry, pop_entry;
    logic              unused_status;

    // Handshake qualifiers; every response is guaranteed a buffer slot by the credit check.
    assign redirect_ok  = branch_flag_i && redirect_target_ok(pc_new_i);
    assign credit_ok    = (SUM_W'(outstanding) + SUM_W'(inst_count)) < SUM_W'(DEPTH);
    assign req_valid_o  = !rst && !branch_flag_i && credit_ok;
    assign req_addr_o   = pc;
    assign issue        = req_valid_o && req_ready_i;
    assign rsp_ok       = rsp_valid_i && (outstanding != '0);
    assign inst_push    = rsp_ok && (drop_cnt == '0) && !redirect_ok;
    assign inst_valid_o = !rst && !branch_flag_i && !inst_empty;
    assign inst_pop     = inst_valid_o && inst_ready_i;

    assign push_entry   = '{pc: tag_pc, inst: rsp_data_i};
    assign inst_o       = pop_entry.inst;
    assign inst_pc_o    = pop_entry.pc;

    // Occupancy of the tag queue mirrors outstanding; status kept only for debug visibility.
    assign unused_status = ^{inst_full, tag_full, tag_empty, tag_count};

    // Next-state for PC, credit and drop counters, and the sticky bad-redirect flag.
    always_comb begin
        pc_next           = pc;
        outstanding_next  = outstanding + CNT_W'(issue) - CNT_W'(rsp_ok);
        drop_cnt_next     = drop_cnt;
        bad_redirect_next = bad_redirect_o;
        if (redirect_ok) begin
            pc_next       = pc_new_i;
            drop_cnt_next = outstanding_next;
        end else begin
            if (issue) begin
                pc_next = pc + 64'd4;
            end
            if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt_next = drop_cnt - CNT_W'(1);
            end
        end
        if (branch_flag_i && !redirect_ok) begin
            bad_redirect_next = 1'b1;
        end
    end

    // Architectural fetch state registers.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc             <= RESET_PC;
            outstanding    <= '0;
            drop_cnt       <= '0;
            bad_redirect_o <= 1'b0;
        end else begin
            pc             <= pc_next;
            outstanding    <= outstanding_next;
            drop_cnt       <= drop_cnt_next;
            bad_redirect_o <= bad_redirect_next;
        end
    end

    // Buffered {pc, inst} pairs waiting for ID; flushed by a valid redirect.
    if_inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_ok),
        .push      (inst_push),
        .push_data (push_entry),
        .pop       (inst_pop),
        .pop_data  (pop_entry),
        .full      (inst_full),
        .empty     (inst_empty),
        .count     (inst_count)
    );

    // PC of each in-flight request; never flushed so dropped responses still retire their tag.
    if_inst_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (issue),
        .push_data (pc),
        .pop       (rsp_ok),
        .pop_data  (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

endmodule
